vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_axis_counter.sv | 64 ++++++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
//   - COORD_W: width of the hcnt/vcnt coordinate counters.
//   - SVGA72_*: 800x600 @ 72 Hz, 50 MHz pixel clock (generator default).
//   - VGA60_*:  640x480 @ 60 Hz, 25.175 MHz pixel clock.
//   - H_TOTAL/V_TOTAL/H_SYNC_*/V_SYNC_*: derived values for the default mode.
package vga_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = 2 ** COORD_W;

  localparam int SVGA72_H_VISIBLE = 800;
  localparam int SVGA72_H_FP      = 56;
  localparam int SVGA72_H_SYNC    = 120;
  localparam int SVGA72_H_BP      = 64;
  localparam int SVGA72_V_VISIBLE = 600;
  localparam int SVGA72_V_FP      = 37;
  localparam int SVGA72_V_SYNC    = 6;
  localparam int SVGA72_V_BP      = 23;
  localparam bit SVGA72_H_POL     = 1'b1;
  localparam bit SVGA72_V_POL     = 1'b1;

  localparam int VGA60_H_VISIBLE = 640;
  localparam int VGA60_H_FP      = 16;
  localparam int VGA60_H_SYNC    = 96;
  localparam int VGA60_H_BP      = 48;
  localparam int VGA60_V_VISIBLE = 480;
  localparam int VGA60_V_FP      = 10;
  localparam int VGA60_V_SYNC    = 2;
  localparam int VGA60_V_BP      = 33;
  localparam bit VGA60_H_POL     = 1'b0;
  localparam bit VGA60_V_POL     = 1'b0;

  function automatic int axis_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int visible, input int fp);
    return visible + fp;
  endfunction

  localparam int H_TOTAL      = axis_total(SVGA72_H_VISIBLE, SVGA72_H_FP,
                                           SVGA72_H_SYNC, SVGA72_H_BP);
  localparam int V_TOTAL      = axis_total(SVGA72_V_VISIBLE, SVGA72_V_FP,
                                           SVGA72_V_SYNC, SVGA72_V_BP);
  localparam int H_SYNC_START = sync_start(SVGA72_H_VISIBLE, SVGA72_H_FP);
  localparam int H_SYNC_END   = H_SYNC_START + SVGA72_H_SYNC - 1;
  localparam int V_SYNC_START = sync_start(SVGA72_V_VISIBLE, SVGA72_V_FP);
  localparam int V_SYNC_END   = V_SYNC_START + SVGA72_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): a wrapping position counter with
// a registered sync decode.
//   pixel_clk  in   pixel clock
//   rst        in   synchronous active-high reset
//   advance    in   step the counter this cycle
//   cnt        out  current position, registered
//   wrap       out  this cycle's advance takes cnt from TOTAL-1 back to 0
//   sync       out  registered sync level for cnt, polarity POL
//   active     out  the position cnt will hold after this edge is visible
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = SVGA72_H_VISIBLE,
  parameter int FP      = SVGA72_H_FP,
  parameter int SYNC    = SVGA72_H_SYNC,
  parameter int BP      = SVGA72_H_BP,
  parameter bit POL     = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               advance,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               sync,
  output logic               active
);

  localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);
  localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] VIS    = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SYNC_S = COORD_W'(sync_start(VISIBLE, FP));
  localparam logic [COORD_W-1:0] SYNC_E = COORD_W'(sync_start(VISIBLE, FP) + SYNC - 1);

  logic [COORD_W-1:0] cnt_q;
  logic [COORD_W-1:0] cnt_nxt;
  logic               sync_q;
  logic               sync_nxt;

  // Decodes look at the value about to be loaded so the registered outputs
  // line up with the count in the same cycle.
  always_comb begin
    wrap    = advance && (cnt_q == LAST);
    cnt_nxt = cnt_q;
    if (advance) begin
      cnt_nxt = wrap ? '0 : cnt_q + COORD_W'(1);
    end
    sync_nxt = ((cnt_nxt >= SYNC_S) && (cnt_nxt <= SYNC_E)) ? POL : ~POL;
    active   = (cnt_nxt < VIS);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sync_q <= ~POL;
    end else if (advance) begin
      cnt_q  <= cnt_nxt;
      sync_q <= sync_nxt;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Every output is a flop, decoded from the
// counter values being loaded, so all outputs describe the hcnt/vcnt visible
// in the same cycle.
//   pixel_clk    in   pixel clock, sole clock
//   rst          in   synchronous active-high reset (overrides en)
//   en           in   advance enable; everything holds when low
//   hcnt/vcnt    out  current column / line
//   hsync/vsync  out  sync pulses, polarity H_POL / V_POL
//   de           out  visible-area display enable
//   line_start   out  first cycle of a line (hcnt newly 0)
//   frame_start  out  first cycle of a frame ((hcnt,vcnt) newly (0,0))
//   frame_cnt    out  completed frames, wraps at 2^16
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = SVGA72_H_VISIBLE,
  parameter int H_FP      = SVGA72_H_FP,
  parameter int H_SYNC    = SVGA72_H_SYNC,
  parameter int H_BP      = SVGA72_H_BP,
  parameter int V_VISIBLE = SVGA72_V_VISIBLE,
  parameter int V_FP      = SVGA72_V_FP,
  parameter int V_SYNC    = SVGA72_V_SYNC,
  parameter int V_BP      = SVGA72_V_BP,
  parameter bit H_POL     = SVGA72_H_POL,
  parameter bit V_POL     = SVGA72_V_POL
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] hcnt,
  output logic [COORD_W-1:0] vcnt,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL_CFG = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL_CFG = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL_CFG > MAX_TOTAL || V_TOTAL_CFG > MAX_TOTAL) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
  end

  logic h_wrap;
  logic v_wrap;
  logic h_active;
  logic v_active;

  logic        de_q;
  logic        line_start_q;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .POL     (H_POL)
  ) u_h_axis (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .advance   (en),
    .cnt       (hcnt),
    .wrap      (h_wrap),
    .sync      (hsync),
    .active    (h_active)
  );

  // The vertical axis steps only on a line wrap, so vsync can only change
  // in the cycle where hcnt becomes 0.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .POL     (V_POL)
  ) u_v_axis (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .advance   (h_wrap),
    .cnt       (vcnt),
    .wrap      (v_wrap),
    .sync      (vsync),
    .active    (v_active)
  );

  // Pulses are only reloaded on enabled cycles, so a stall holds a pulse
  // high rather than generating a second event.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (en) begin
      de_q          <= h_active && v_active;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800-pixel line timing with a shortened
// 10-line frame (4 visible, 2 FP, 2 sync, 2 BP) so full frames stay short.
module tb_vga_timing_gen;

  localparam int HV = 800, HF = 56, HS = 120, HB = 64;
  localparam int VV = 4,   VF = 2,  VS = 2,   VB = 2;
  localparam int HT = HV + HF + HS + HB;   // 1040
  localparam int VT = VV + VF + VS + VB;   // 10

  logic        pixel_clk;
  logic        rst;
  logic        en;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL (1'b1), .V_POL (1'b1)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .en          (en),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  initial pixel_clk = 1'b0;
  always #10 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int          m_h, m_v;
  logic [15:0] m_f;
  logic        m_ls, m_fs;
  bit          mon_on;

  // running statistics
  int   coord_err, dec_err, pulse_err;
  int   hs_cnt, hs_first, hs_last, de_cnt, de_last, de_late;
  int   ls_cnt, fs_cnt, vs_cnt, vs_min, vs_max, vs_bad;
  logic prev_vsync;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    coord_err = 0; dec_err = 0; pulse_err = 0;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    de_cnt = 0; de_last = -1; de_late = 0;
    ls_cnt = 0; fs_cnt = 0; vs_cnt = 0; vs_min = 9999; vs_max = -1; vs_bad = 0;
    prev_vsync = vsync;
  endtask

  task automatic monitor();
    logic exp_hs, exp_vs, exp_de;
    exp_hs = (m_h >= HV + HF) && (m_h <= HV + HF + HS - 1);
    exp_vs = (m_v >= VV + VF) && (m_v <= VV + VF + VS - 1);
    exp_de = (m_h < HV) && (m_v < VV);
    if (hcnt != 11'(m_h) || vcnt != 11'(m_v) || frame_cnt != m_f) coord_err++;
    if (hsync !== exp_hs || vsync !== exp_vs || de !== exp_de) dec_err++;
    if (line_start !== m_ls || frame_start !== m_fs) pulse_err++;
    if (frame_start && !line_start) pulse_err++;
    if (hsync && vcnt == 0) begin
      hs_cnt++;
      if (hs_first < 0) hs_first = int'(hcnt);
      hs_last = int'(hcnt);
    end
    if (de && vcnt == 0) begin
      de_cnt++;
      de_last = int'(hcnt);
    end
    if (de && vcnt >= VV) de_late++;
    if (vsync) begin
      vs_cnt++;
      if (int'(vcnt) < vs_min) vs_min = int'(vcnt);
      if (int'(vcnt) > vs_max) vs_max = int'(vcnt);
    end
    if (vsync !== prev_vsync && hcnt != 0) vs_bad++;
    prev_vsync = vsync;
    ls_cnt += int'(line_start);
    fs_cnt += int'(frame_start);
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    if (rst) begin
      m_h = 0; m_v = 0; m_f = '0; m_ls = 1'b0; m_fs = 1'b0;
    end else if (en) begin
      m_ls = 1'b0; m_fs = 1'b0;
      if (m_h == HT - 1) begin
        m_h = 0; m_ls = 1'b1;
        if (m_v == VT - 1) begin
          m_v = 0; m_fs = 1'b1; m_f = m_f + 16'd1;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
    @(negedge pixel_clk);
    if (mon_on) monitor();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_pos(input int h, input int v, input int budget, input string tag);
    int n;
    n = 0;
    while (!(hcnt == 11'(h) && vcnt == 11'(v)) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(hcnt == 11'(h) && vcnt == 11'(v)), 32'd1);
  endtask

  logic [10:0] s_h, s_v;
  logic [15:0] s_f;
  logic [4:0]  s_flags;
  int          stall_err;

  initial begin
    rst = 1'b1; en = 1'b0; mon_on = 1'b0;
    m_h = 0; m_v = 0; m_f = '0; m_ls = 1'b0; m_fs = 1'b0;
    @(negedge pixel_clk);
    run(3);

    // reset state
    chk("rst_hcnt", 32'(hcnt), 32'd0);
    chk("rst_vcnt", 32'(vcnt), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_de", 32'(de), 32'd1);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_line_start", 32'(line_start), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);

    // first line
    rst = 1'b0; en = 1'b1;
    clear_stats();
    mon_on = 1'b1;
    run(HT);
    chk("line0_hcnt_wrap", 32'(hcnt), 32'd0);
    chk("line0_vcnt", 32'(vcnt), 32'd1);
    chk("line0_line_start", 32'(line_start), 32'd1);
    chk("line0_ls_count", 32'(ls_cnt), 32'd1);
    chk("line0_fs_count", 32'(fs_cnt), 32'd0);
    chk("line0_hs_first", 32'(hs_first), 32'd856);
    chk("line0_hs_last", 32'(hs_last), 32'd975);
    chk("line0_hs_count", 32'(hs_cnt), 32'd120);
    chk("line0_de_count", 32'(de_cnt), 32'd799);
    chk("line0_de_last", 32'(de_last), 32'd799);

    // rest of the first frame
    run(HT * VT - HT);
    chk("frm1_hcnt", 32'(hcnt), 32'd0);
    chk("frm1_vcnt", 32'(vcnt), 32'd0);
    chk("frm1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("frm1_frame_start", 32'(frame_start), 32'd1);
    chk("frm1_fs_count", 32'(fs_cnt), 32'd1);
    chk("frm1_ls_count", 32'(ls_cnt), 32'd10);
    chk("frm1_vs_min", 32'(vs_min), 32'd6);
    chk("frm1_vs_max", 32'(vs_max), 32'd7);
    chk("frm1_vs_count", 32'(vs_cnt), 32'd2080);
    chk("frm1_vs_midline_change", 32'(vs_bad), 32'd0);
    chk("frm1_de_blank", 32'(de_late), 32'd0);
    chk("frm1_coord_err", 32'(coord_err), 32'd0);
    chk("frm1_decode_err", 32'(dec_err), 32'd0);
    chk("frm1_pulse_err", 32'(pulse_err), 32'd0);

    // stall on the last pixel of the frame
    run(HT * VT - 1);
    chk("pre_stall_hcnt", 32'(hcnt), 32'd1039);
    chk("pre_stall_vcnt", 32'(vcnt), 32'd9);
    chk("pre_stall_flags", 32'({hsync, vsync, de, line_start, frame_start}), 32'd0);
    s_h = hcnt; s_v = vcnt; s_f = frame_cnt;
    s_flags = {hsync, vsync, de, line_start, frame_start};
    stall_err = 0;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hcnt != s_h || vcnt != s_v || frame_cnt != s_f ||
          {hsync, vsync, de, line_start, frame_start} != s_flags) stall_err++;
    end
    chk("stall_frozen", 32'(stall_err), 32'd0);
    en = 1'b1;
    tick();
    chk("resume_hcnt", 32'(hcnt), 32'd0);
    chk("resume_vcnt", 32'(vcnt), 32'd0);
    chk("resume_frame_start", 32'(frame_start), 32'd1);
    chk("resume_line_start", 32'(line_start), 32'd1);
    chk("resume_frame_cnt", 32'(frame_cnt), 32'd2);
    en = 1'b0;
    run(3);
    chk("stall_pulse_held", 32'(frame_start), 32'd1);
    chk("stall_frame_cnt", 32'(frame_cnt), 32'd2);
    en = 1'b1;
    tick();
    chk("post_stall_fs", 32'(frame_start), 32'd0);
    chk("post_stall_hcnt", 32'(hcnt), 32'd1);
    chk("post_stall_frame_cnt", 32'(frame_cnt), 32'd2);

    // reset in mid-frame
    run_until_pos(500, 3, 5000, "mid_reach");
    rst = 1'b1;
    tick();
    chk("midrst_hcnt", 32'(hcnt), 32'd0);
    chk("midrst_vcnt", 32'(vcnt), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_de", 32'(de), 32'd1);
    chk("midrst_syncs", 32'({hsync, vsync}), 32'd0);
    chk("midrst_pulses", 32'({line_start, frame_start}), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_exit_hcnt", 32'(hcnt), 32'd1);
    chk("midrst_exit_ls", 32'(line_start), 32'd0);

    // frame counter rollover from 0xFFFF
    mon_on = 1'b0;
    en = 1'b0;
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("preload_frame_cnt", 32'(frame_cnt), 32'h0000FFFF);
    m_f = 16'hFFFF;
    clear_stats();
    mon_on = 1'b1;
    en = 1'b1;
    begin
      int n;
      n = 0;
      while (!frame_start && n < HT * VT + 10) begin
        tick();
        n++;
      end
    end
    chk("wrap_frame_start_seen", 32'(frame_start), 32'd1);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("wrap_coord_err", 32'(coord_err), 32'd0);
    chk("wrap_pulse_err", 32'(pulse_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
